// File: rtl/alu_pkg.sv
// Shared encodings for the SAP arithmetic/logic stage: op codes, FSM states,
// flag bit positions and a flag-packing helper.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned FLG_C = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_N = 1;
   localparam int unsigned FLG_V = 0;

   typedef logic [3:0] alu_flags_t;

   function automatic alu_flags_t make_flags(input logic c, input logic z, input logic n,
                                             input logic v);
      alu_flags_t f;
      f        = '0;
      f[FLG_C] = c;
      f[FLG_Z] = z;
      f[FLG_N] = n;
      f[FLG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Operand/op request and result/flags response bundle between the SAP control
// path (master) and the ALU stage (slave).
interface alu_unit_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [2:0]       op;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;

   modport master (
      output a_in, b_in, op, start,
      input  busy, done, result, flags
   );

   modport slave (
      input  a_in, b_in, op, start,
      output busy, done, result, flags
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial-product add per step, WIDTH steps per product.
// product is the accumulator value this step produces, so the final step can be captured on its edge.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               last_step
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;

   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign product   = acc_d;
   assign last_step = step && (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (load) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         cnt_q    <= '0;
      end else if (step) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_unit.sv
// Arithmetic/logic stage of the SAP datapath: single-cycle ops plus a sequential
// multiply, with a start/busy/done handshake and registered result and flags.
module alu_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input logic       clk,
   input logic       rst,
   alu_unit_if.slave bus
);

   localparam int unsigned MSB = WIDTH - 1;

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic [WIDTH-1:0]   result_q;
   alu_flags_t         flags_q;

   logic               accept;
   logic               is_mul;
   logic               mul_load;
   logic               mul_step;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH-1:0]   mul_res;
   logic               mul_c;

   assign accept   = (state_q == ST_IDLE) && bus.start;
   assign is_mul   = (bus.op == OP_MUL);
   assign mul_load = accept && is_mul;
   assign mul_step = (state_q == ST_RUN);

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul_seq (
      .clk       (clk),
      .rst       (rst),
      .load      (mul_load),
      .step      (mul_step),
      .a         (bus.a_in),
      .b         (bus.b_in),
      .product   (mul_product),
      .last_step (mul_last)
   );

   assign mul_res = mul_product[WIDTH-1:0];
   assign mul_c   = |mul_product[2*WIDTH-1:WIDTH];

   // Single-cycle datapath; evaluated on the live operands, captured only on accept.
   always_comb begin
      sum     = {1'b0, bus.a_in} + {1'b0, bus.b_in};
      diff    = {1'b0, bus.a_in} - {1'b0, bus.b_in};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (bus.a_in[MSB] == bus.b_in[MSB]) && (sum[MSB] != bus.a_in[MSB]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (bus.a_in[MSB] != bus.b_in[MSB]) && (diff[MSB] != bus.a_in[MSB]);
         end
         OP_AND: alu_res = bus.a_in & bus.b_in;
         OP_OR:  alu_res = bus.a_in | bus.b_in;
         OP_XOR: alu_res = bus.a_in ^ bus.b_in;
         OP_SHL: begin
            alu_res = bus.a_in << 1;
            alu_c   = bus.a_in[MSB];
         end
         OP_SHR: begin
            alu_res = bus.a_in >> 1;
            alu_c   = bus.a_in[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = is_mul ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (mul_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept && !is_mul) begin
            result_q <= alu_res;
            flags_q  <= make_flags(alu_c, alu_res == '0, alu_res[MSB], alu_v);
         end else if (mul_last) begin
            result_q <= mul_res;
            flags_q  <= make_flags(mul_c, mul_res == '0, mul_res[MSB], 1'b0);
         end
      end
   end

   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;
   assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected results are queued at issue and
// compared when done pulses, including latency, ignored starts and mid-run reset.
module tb_alu_unit;
   import alu_pkg::*;

   typedef struct {
      logic [15:0] result;
      logic [3:0]  flags;
      int          start_cyc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   int   cyc      = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_unit_if #(.WIDTH(16)) bus ();

   alu_unit #(
      .WIDTH(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model, flags packed {C,Z,N,V}.
   function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      logic [31:0] p;
      logic [15:0] r;
      logic        c;
      logic        v;
      int          sr;
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (op)
         OP_ADD: begin
            p  = 32'(a) + 32'(b);
            r  = p[15:0];
            c  = p[16];
            sr = int'($signed(a)) + int'($signed(b));
            v  = (sr > 32767) || (sr < -32768);
         end
         OP_SUB: begin
            r  = a - b;
            c  = (a < b);
            sr = int'($signed(a)) - int'($signed(b));
            v  = (sr > 32767) || (sr < -32768);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SHL: begin
            r = {a[14:0], 1'b0};
            c = a[15];
         end
         OP_SHR: begin
            r = {1'b0, a[15:1]};
            c = a[0];
         end
         default: begin
            p = 32'(a) * 32'(b);
            r = p[15:0];
            c = (p[31:16] != 16'h0);
         end
      endcase
      return {c, (r == 16'h0), r[15], v, r};
   endfunction

   always @(negedge clk) begin
      if (bus.done) begin
         exp_t e;
         n_done++;
         check_eq("sb_has_entry_at_done", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("result", 32'(bus.result), 32'(e.result));
            check_eq("flags", 32'(bus.flags), 32'(e.flags));
            check_eq("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            check_eq("busy_at_done", 32'(bus.busy), 32'd1);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [19:0] m;
      exp_t        e;
      m           = model(op, a, b);
      e.result    = m[15:0];
      e.flags     = m[19:16];
      e.start_cyc = cyc;
      e.lat       = (op == OP_MUL) ? 17 : 1;
      exp_q.push_back(e);
      bus.op    = op;
      bus.a_in  = a;
      bus.b_in  = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_done_seen"}, 32'(bus.done), 32'd1);
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_busy_cleared"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b);
      issue(op, a, b);
      wait_done(tag);
   endtask

   initial begin
      int d0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a_in  = 16'h0;
      bus.b_in  = 16'h0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_result", 32'(bus.result), 32'd0);
      check_eq("rst_flags", 32'(bus.flags), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001);
      run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001);
      run_op("sub_borrow", OP_SUB, 16'h0001, 16'h0002);
      run_op("mul_small", OP_MUL, 16'h0003, 16'h0005);
      run_op("mul_hi", OP_MUL, 16'h0100, 16'h0100);
      run_op("shl", OP_SHL, 16'h8001, 16'h0000);
      run_op("shr", OP_SHR, 16'h0003, 16'h0000);
      run_op("and", OP_AND, 16'hF0F0, 16'h3C3C);
      run_op("or", OP_OR, 16'hF000, 16'h000F);
      run_op("xor", OP_XOR, 16'hAAAA, 16'hAAAA);
      run_op("add_vpos", OP_ADD, 16'h7FFF, 16'h0001);

      for (int i = 0; i < 24; i++) begin
         run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      end

      // Start while busy is dropped; operand changes mid-run must not leak in.
      d0 = n_done;
      issue(OP_MUL, 16'h1234, 16'h0056);
      repeat (4) @(negedge clk);
      bus.op    = OP_ADD;
      bus.a_in  = 16'hFFFF;
      bus.b_in  = 16'h0001;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("mul_ignore");
      repeat (3) @(negedge clk);
      check_eq("mul_ignore_single_done", 32'(n_done - d0), 32'd1);

      // Abort a multiply partway through.
      run_op("pre_abort", OP_XOR, 16'h1234, 16'h0000);
      d0 = n_done;
      issue(OP_MUL, 16'h00FF, 16'h0101);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      check_eq("abort_result", 32'(bus.result), 32'd0);
      check_eq("abort_flags", 32'(bus.flags), 32'd0);
      repeat (20) @(negedge clk);
      check_eq("abort_no_done", 32'(n_done - d0), 32'd0);
      run_op("post_abort_add", OP_ADD, 16'h1111, 16'h2222);

      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
# alu_unit

Arithmetic/logic stage of the 16-bit SAP datapath. It sits directly downstream of the A and B registers and consumes their outputs as operands. Single-cycle ops complete in one cycle; MUL is a 16-iteration shift-add sequence. Completion is signalled through a start/busy/done handshake. It holds a registered result, which the control unit gates onto the bus, and a 4-bit flags register, which feeds conditional jumps.

## Interface
Parameters:
- WIDTH, 16, operand/result width (design verified at 16 only)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- a_in  in  16  operand A (A register output)
- b_in  in  16  operand B (B register output)
- op  in  3  operation select, sampled with start
- start  in  1  single-cycle request; accepted only when busy=0
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result/flags valid and updated
- result  out  16  registered result; holds until next completion
- flags  out  4  {C,Z,N,V} = bits [3:0]; holds until next completion

## Operation
- Op encoding:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: a<<1
  - 110 SHR: logical a>>1
  - 111 MUL: low 16 bits of a*b
- Operands and op are latched on the accepting edge; later changes on a_in/b_in/op have no effect.
- States:
  - IDLE: accepts start. Any non-MUL op → DONE; MUL → RUN.
  - RUN: one shift-add iteration per cycle with a 4-bit count. After the 16th iteration → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- Single-cycle ops: result and flags are written on the accepting edge.
- MUL datapath: 32-bit accumulator, 32-bit left-shifting multiplicand, 16-bit right-shifting multiplier. Result and flags are written on the 16th RUN edge.
- Flags, computed from the 16-bit result:
  - Z = (result==0)
  - N = result[15]
  - C:
    - ADD: carry-out
    - SUB: borrow, i.e. 1 iff a<b unsigned
    - SHL: a[15]
    - SHR: a[0]
    - MUL: 1 iff product[31:16]!=0
    - logic ops: 0
  - V: signed overflow for ADD/SUB; 0 for all other ops
- start while busy=1 (RUN or DONE): ignored, not queued.
- Reset values: state IDLE, result 0x0000, flags 4'b0000, busy 0, done 0, internal counters/accumulators 0.
- rst mid-RUN: abort; outputs take reset values next cycle; no done pulse is produced.

## Timing
- Non-MUL: start sampled at edge k → done=1 and new result/flags visible in cycle k+1 → busy=0 from edge k+2.
- MUL: start at edge k → RUN for edges k+1..k+16 → done=1 in the cycle after edge k+16 (17 cycles after start).
- Earliest back-to-back start: the cycle after done.
- busy rises the cycle after the accepting edge.
- Result and flags are stable between done pulses.

## Structure
- Package alu_pkg holds:
  - op encoding localparams (OP_ADD..OP_MUL)
  - state encoding (ST_IDLE, ST_RUN, ST_DONE)
  - flag bit indices (FLG_C=3, FLG_Z=2, FLG_N=1, FLG_V=0)
- Sub-module alu_mul_seq: shift-add multiplier with load/step/count. It exports a 32-bit product and last_step.
- Single-cycle ops are a combinational case block in alu_unit feeding the result/flags registers.

## Test plan
- ADD a=0xFFFF b=0x0001 → result 0x0000, flags C=1 Z=1 N=0 V=0; done exactly 1 cycle after start.
- SUB a=0x8000 b=0x0001 → result 0x7FFF, C=0 Z=0 N=0 V=1. SUB a=0x0001 b=0x0002 → 0xFFFF, C=1 N=1.
- MUL a=0x0003 b=0x0005 → 0x000F, C=0, done 17 cycles after start. MUL a=0x0100 b=0x0100 → 0x0000, C=1 Z=1.
- SHL a=0x8001 → 0x0002, C=1. SHR a=0x0003 → 0x0001, C=1.
- Start MUL, pulse start with op=ADD at RUN cycle 5 → ignored; MUL result correct; single done pulse.
- Assert rst at RUN cycle 8 → next cycle busy=0, result 0x0000, flags 0, no done. A fresh ADD afterwards works normally.
